stack_drain: RTL and testbench

STACK_DRAIN -- requirements
Module: stack_drain

---
 rtl/stack_pkg.sv | 18 +
 rtl/stack_drain_if.sv | 35 +++
 rtl/stack_drain_hold_timer.sv | 38 +++
 rtl/stack_drain.sv | 149 ++++++++++++++
 tb/tb_stack_drain.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stack_pkg.sv
// stack_pkg -- shared definitions for the stack and its drain controller:
// drain FSM state encoding and the default stack geometry.
package stack_pkg;

  // Default width of one stack entry and log2 of the stack depth.
  localparam int DATA_SIZE_DEF      = 32'sd3;
  localparam int ADDR_SPACE_EXP_DEF = 32'sd2;

  // Drain controller states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_PRESENT = 3'd2,
    ST_HOLD    = 3'd3,
    ST_DONE    = 3'd4
  } drain_state_t;

endpackage

// File: rtl/stack_drain_if.sv
// stack_drain_if -- groups the stack-side pop handshake and the downstream
// valid/ready item channel of the drain controller.
// master: the drain controller; slave: the stack plus downstream sink.
interface stack_drain_if
  import stack_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF
) ();

  logic                 stack_empty;
  logic [DATA_SIZE-1:0] stack_data;
  logic                 stack_pop;
  logic [DATA_SIZE-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    input  stack_empty,
    input  stack_data,
    input  out_ready,
    output stack_pop,
    output out_data,
    output out_valid
  );

  modport slave (
    output stack_empty,
    output stack_data,
    output out_ready,
    input  stack_pop,
    input  out_data,
    input  out_valid
  );

endinterface

// File: rtl/stack_drain_hold_timer.sv
// hold_timer -- countdown that times the idle gap after each accepted item.
// Only built when STACK_DRAIN_HOLD_EN is defined; without it the drain
// controller has no HOLD gap and this module does not exist.
`ifdef STACK_DRAIN_HOLD_EN
module hold_timer #(
  parameter int HOLD_CYCLES = 32'sd100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int CW = (HOLD_CYCLES > 32'sd1) ? $clog2(HOLD_CYCLES) : 32'sd1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(HOLD_CYCLES - 32'sd1);
  localparam logic [CW-1:0] ONE      = CW'(1'b1);
  localparam logic [CW-1:0] ZERO     = CW'(1'b0);

  logic [CW-1:0] remaining;

  // Load on HOLD entry, then count down to zero and stay there.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      remaining <= ZERO;
    end else if (load) begin
      remaining <= LOAD_VAL;
    end else if (en && (remaining != ZERO)) begin
      remaining <= remaining - ONE;
    end else begin
      remaining <= remaining;
    end
  end

  assign expired = (remaining == ZERO);

endmodule
`endif

// File: rtl/stack_drain.sv
// stack_drain -- pops a stack one entry at a time and presents each entry on
// a valid/ready channel until the stack is empty or the drain is aborted.
// Optional feature macro: STACK_DRAIN_HOLD_EN adds a HOLD_CYCLES idle gap
// after every accepted item (HOLD state plus hold_timer); without it an
// accepted item leads straight to the next FETCH.
module stack_drain
  import stack_pkg::*;
#(
  parameter int DATA_SIZE      = DATA_SIZE_DEF,
  parameter int ADDR_SPACE_EXP = ADDR_SPACE_EXP_DEF,
  parameter int HOLD_CYCLES    = 32'sd100_000_000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  stack_drain_if.master           bus,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_SPACE_EXP:0] count
);

  localparam logic [ADDR_SPACE_EXP:0] DEPTH   = {1'b1, {ADDR_SPACE_EXP{1'b0}}};
  localparam logic [ADDR_SPACE_EXP:0] CNT_ONE = (ADDR_SPACE_EXP + 1)'(1'b1);
  localparam logic [ADDR_SPACE_EXP:0] CNT_ZERO = (ADDR_SPACE_EXP + 1)'(1'b0);

  drain_state_t         state;
  logic [DATA_SIZE-1:0] item_data;
  logic                 item_valid;
  logic                 pop;
  logic                 accept;

  // A pop happens in the FETCH cycle itself, so it follows the live empty
  // flag; abort suppresses it so an aborted drain never removes another item.
  assign pop    = (state == ST_FETCH) && !bus.stack_empty && !abort;
  assign accept = (state == ST_PRESENT) && bus.out_ready && !abort;

  assign bus.stack_pop = pop;
  assign bus.out_data  = item_data;
  assign bus.out_valid = item_valid;

  // HOLD_CYCLES below 1 is not a legal configuration; this empty block only
  // names that constraint.
  if (HOLD_CYCLES < 32'sd1) begin : g_hold_cycles_illegal
  end

`ifdef STACK_DRAIN_HOLD_EN
  localparam drain_state_t AFTER_ACCEPT = ST_HOLD;

  logic hold_en;
  logic hold_expired;

  assign hold_en = (state == ST_HOLD) && !abort;

  hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (accept),
    .en      (hold_en),
    .expired (hold_expired)
  );
`else
  localparam drain_state_t AFTER_ACCEPT = ST_FETCH;
`endif

  // Drain FSM: state and all registered outputs advance together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      item_data  <= {DATA_SIZE{1'b0}};
      item_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      count      <= CNT_ZERO;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !abort) begin
            count <= CNT_ZERO;
            busy  <= 1'b1;
            state <= ST_FETCH;
          end else begin
            state <= ST_IDLE;
          end
        end

        ST_FETCH: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (bus.stack_empty) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            item_data  <= bus.stack_data;
            item_valid <= 1'b1;
            if (count != DEPTH) begin
              count <= count + CNT_ONE;
            end else begin
              count <= count;
            end
            state <= ST_PRESENT;
          end
        end

        ST_PRESENT: begin
          if (abort) begin
            item_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= ST_IDLE;
          end else if (accept) begin
            item_valid <= 1'b0;
            state      <= AFTER_ACCEPT;
          end else begin
            state <= ST_PRESENT;
          end
        end

`ifdef STACK_DRAIN_HOLD_EN
        ST_HOLD: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (hold_expired) begin
            state <= ST_FETCH;
          end else begin
            state <= ST_HOLD;
          end
        end
`endif

        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          item_valid <= 1'b0;
          busy       <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_drain.sv
// tb_stack_drain -- directed self-checking bench for stack_drain with a small
// behavioural stack. Expected gap after each item depends on whether
// STACK_DRAIN_HOLD_EN is defined.
module tb_stack_drain;

  localparam int DS = 3;
  localparam int AE = 2;
  localparam int HC = 4;
`ifdef STACK_DRAIN_HOLD_EN
  localparam int GAP = HC;
`else
  localparam int GAP = 0;
`endif

  logic          clk   = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          busy;
  logic          done;
  logic [AE:0]   count;

  stack_drain_if #(.DATA_SIZE(DS)) bus ();

  stack_drain #(
    .DATA_SIZE      (DS),
    .ADDR_SPACE_EXP (AE),
    .HOLD_CYCLES    (HC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .abort (abort),
    .bus   (bus),
    .busy  (busy),
    .done  (done),
    .count (count)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural stack ----------------
  logic [DS-1:0] mem [0:3];
  logic [DS-1:0] ld_vals [0:3];
  logic          ld_en = 1'b0;
  int            ld_n  = 0;
  int            sp    = 0;

  // Stack model: bulk load from the bench, otherwise pop on stack_pop.
  always @(posedge clk) begin
    if (ld_en) begin
      for (int k = 0; k < 4; k++) mem[k] <= ld_vals[k];
      sp <= ld_n;
    end else if (bus.stack_pop && sp > 0) begin
      sp <= sp - 1;
    end
  end

  assign bus.stack_empty = (sp == 0);
  assign bus.stack_data  = (sp > 0) ? mem[2'(sp - 1)] : {DS{1'b0}};

  // ---------------- monitor ----------------
  int            cyc      = 0;
  int            pop_n    = 0;
  int            dbl_pop  = 0;
  int            done_n   = 0;
  int            busy_n   = 0;
  int            acc_n    = 0;
  logic          prev_pop = 1'b0;
  int            pop_at [0:63];
  logic [DS-1:0] acc [0:63];

  // Observe the DUT mid-cycle and log pops, accepted items and pulses.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.stack_pop) begin
      pop_at[pop_n[5:0]] <= cyc;
      pop_n <= pop_n + 1;
      if (prev_pop) dbl_pop <= dbl_pop + 1;
    end
    prev_pop <= bus.stack_pop;
    if (bus.out_valid && bus.out_ready) begin
      acc[acc_n[5:0]] <= bus.out_data;
      acc_n <= acc_n + 1;
    end
    if (done) done_n <= done_n + 1;
    if (busy) busy_n <= busy_n + 1;
  end

  // ---------------- checking ----------------
  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic load_stack(input int n, input logic [DS-1:0] v0, input logic [DS-1:0] v1,
                            input logic [DS-1:0] v2, input logic [DS-1:0] v3);
    ld_vals[0] = v0;
    ld_vals[1] = v1;
    ld_vals[2] = v2;
    ld_vals[3] = v3;
    ld_n  = n;
    ld_en = 1'b1;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy && k < 300) begin
      tick();
      k++;
    end
    check_eq(tag, 32'(busy), 32'd0);
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    while (!bus.out_valid && k < 100) begin
      tick();
      k++;
    end
    check_eq(tag, 32'(bus.out_valid), 32'd1);
  endtask

  int b_pop, b_acc, b_done, b_busy;

  task automatic snap();
    b_pop  = pop_n;
    b_acc  = acc_n;
    b_done = done_n;
    b_busy = busy_n;
  endtask

  // Watchdog: the bench must never hang.
  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    bus.out_ready = 1'b0;

    // ---- reset state ----
    #2;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_pop", 32'(bus.stack_pop), 32'd0);
    tick(); tick(); tick();
    reset = 1'b1;
    tick();

    // ---- full drain 5,3,6 (6 on top), ready always high ----
    load_stack(3, 3'd5, 3'd3, 3'd6, 3'd0);
    bus.out_ready = 1'b1;
    snap();
    pulse_start();
    check_eq("lat_busy", 32'(busy), 32'd1);
    check_eq("lat_pop", 32'(bus.stack_pop), 32'd1);
    tick();
    check_eq("lat_valid", 32'(bus.out_valid), 32'd1);
    check_eq("lat_data", 32'(bus.out_data), 32'd6);
    wait_idle("drain_idle");
    check_eq("drain_items", 32'(acc_n - b_acc), 32'd3);
    check_eq("drain_item0", 32'(acc[b_acc]), 32'd6);
    check_eq("drain_item1", 32'(acc[b_acc + 1]), 32'd3);
    check_eq("drain_item2", 32'(acc[b_acc + 2]), 32'd5);
    check_eq("drain_pops", 32'(pop_n - b_pop), 32'd3);
    check_eq("drain_gap01", 32'(pop_at[b_pop + 1] - pop_at[b_pop]), 32'(GAP + 2));
    check_eq("drain_gap12", 32'(pop_at[b_pop + 2] - pop_at[b_pop + 1]), 32'(GAP + 2));
    check_eq("drain_done", 32'(done_n - b_done), 32'd1);
    check_eq("drain_count", 32'(count), 32'd3);
    check_eq("drain_sp", 32'(sp), 32'd0);

    // ---- start on an empty stack ----
    snap();
    pulse_start();
    wait_idle("empty_idle");
    tick();
    check_eq("empty_pops", 32'(pop_n - b_pop), 32'd0);
    check_eq("empty_done", 32'(done_n - b_done), 32'd1);
    check_eq("empty_count", 32'(count), 32'd0);
    check_eq("empty_busy_cycles", 32'(busy_n - b_busy), 32'd2);

    // ---- back-pressure: ready low for 10 cycles in PRESENT ----
    load_stack(1, 3'd7, 3'd0, 3'd0, 3'd0);
    bus.out_ready = 1'b0;
    snap();
    pulse_start();
    tick();
    for (int i = 0; i < 10; i++) begin
      check_eq("stall_valid", 32'(bus.out_valid), 32'd1);
      check_eq("stall_data", 32'(bus.out_data), 32'd7);
      tick();
    end
    check_eq("stall_pops", 32'(pop_n - b_pop), 32'd1);
    bus.out_ready = 1'b1;
    wait_idle("stall_idle");
    check_eq("stall_count", 32'(count), 32'd1);
    check_eq("stall_done", 32'(done_n - b_done), 32'd1);

    // ---- abort while the second item is presented ----
    load_stack(4, 3'd1, 3'd2, 3'd3, 3'd4);
    bus.out_ready = 1'b0;
    snap();
    pulse_start();
    wait_valid("abort_v1");
    check_eq("abort_item0", 32'(bus.out_data), 32'd4);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    wait_valid("abort_v2");
    check_eq("abort_item1", 32'(bus.out_data), 32'd3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_valid", 32'(bus.out_valid), 32'd0);
    tick(); tick(); tick();
    check_eq("abort_count", 32'(count), 32'd2);
    check_eq("abort_sp", 32'(sp), 32'd2);
    check_eq("abort_done", 32'(done_n - b_done), 32'd0);
    check_eq("abort_pops", 32'(pop_n - b_pop), 32'd2);
    check_eq("abort_accepted", 32'(acc_n - b_acc), 32'd1);

    // ---- full stack: count reaches the depth ----
    load_stack(4, 3'd0, 3'd1, 3'd2, 3'd7);
    bus.out_ready = 1'b1;
    snap();
    pulse_start();
    wait_idle("full_idle");
    check_eq("full_count", 32'(count), 32'd4);
    check_eq("full_sp", 32'(sp), 32'd0);
    check_eq("full_last", 32'(acc[acc_n - 1]), 32'd0);

    // ---- start pulsed during PRESENT is ignored ----
    load_stack(3, 3'd5, 3'd3, 3'd6, 3'd0);
    bus.out_ready = 1'b0;
    snap();
    pulse_start();
    wait_valid("restart_v");
    pulse_start();
    check_eq("restart_count_mid", 32'(count), 32'd1);
    bus.out_ready = 1'b1;
    wait_idle("restart_idle");
    check_eq("restart_items", 32'(acc_n - b_acc), 32'd3);
    check_eq("restart_item0", 32'(acc[b_acc]), 32'd6);
    check_eq("restart_item1", 32'(acc[b_acc + 1]), 32'd3);
    check_eq("restart_item2", 32'(acc[b_acc + 2]), 32'd5);
    check_eq("restart_count", 32'(count), 32'd3);
    check_eq("restart_done", 32'(done_n - b_done), 32'd1);

    // ---- reset in the middle of a drain, then resume ----
    load_stack(3, 3'd5, 3'd3, 3'd6, 3'd0);
    bus.out_ready = 1'b1;
    pulse_start();
    tick();
    tick();
    reset = 1'b0;
    #1;
    check_eq("mrst_busy", 32'(busy), 32'd0);
    check_eq("mrst_valid", 32'(bus.out_valid), 32'd0);
    check_eq("mrst_done", 32'(done), 32'd0);
    check_eq("mrst_count", 32'(count), 32'd0);
    check_eq("mrst_data", 32'(bus.out_data), 32'd0);
    check_eq("mrst_pop", 32'(bus.stack_pop), 32'd0);
    tick(); tick();
    check_eq("mrst_sp", 32'(sp), 32'd2);
    reset = 1'b1;
    tick();
    snap();
    pulse_start();
    wait_idle("mrst_idle");
    check_eq("mrst_items", 32'(acc_n - b_acc), 32'd2);
    check_eq("mrst_item0", 32'(acc[b_acc]), 32'd3);
    check_eq("mrst_item1", 32'(acc[b_acc + 1]), 32'd5);
    check_eq("mrst_count_after", 32'(count), 32'd2);
    check_eq("mrst_sp_after", 32'(sp), 32'd0);
    check_eq("mrst_done_after", 32'(done_n - b_done), 32'd1);

    // ---- pops never on consecutive cycles ----
    check_eq("no_double_pop", 32'(dbl_pop), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
